keypad_scanner: RTL
===================

Name: keypad_scanner

Overview:
- Drives and reads a 4x3 matrix keypad (rows 1-2-3 / 4-5-6 / 7-8-9 / *-0-#).
- Debounces presses and reports each accepted press as a one-hot 12-bit code with a single-cycle valid pulse.
- Sourcing end of the scan_data/valid interface consumed by the digit-entry/display block.
- Bit index = row*3 + col: bits 0..8 = keys 1..9, bit 9 = *, bit 10 = 0, bit 11 = #.

Parameters:
- SCAN_DIV, 1000: clock cycles each column is driven. A sample tick occurs on the last cycle of each dwell. Minimum 2.
- DEBOUNCE, 4: consecutive matching sample ticks required to accept a press, and likewise to accept a release. Minimum 1.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  asynchronous, active-low reset.
- row  input  4  keypad rows, active-low with external pull-ups, asynchronous to clk.
- col  output 3  column drive, active-low, one-cold (exactly one bit low outside reset).
- scan_data  output 12  one-hot code of the last accepted key.
- valid  output 1  one-cycle pulse when scan_data carries a new key.

Behaviour:
- Reset (rst=0, async): state=SCAN, col_idx=0, divider=0, debounce count=0, col=3'b110, scan_data=12'h000, valid=0, synchronizer flops=4'b1111.
- row passes through a 2-flop synchronizer. All decisions use the synchronized value rs.
- Divider counts 0..SCAN_DIV-1 and wraps. A tick is asserted when divider==SCAN_DIV-1. The divider runs in every state.
- col = ~(3'b001 << col_idx).
- States SCAN, DEBOUNCE, REPORT, RELEASE:
  - SCAN: on each tick, evaluate rs.
    - Exactly one rs bit low: capture row_idx, keep col_idx, set count=1, go to DEBOUNCE. If DEBOUNCE==1, go straight to REPORT.
    - All high, or two or more low: col_idx advances 0->1->2->0.
  - DEBOUNCE: col_idx held. On each tick:
    - Same single row low: count+1. When count reaches DEBOUNCE, go to REPORT.
    - Otherwise (released, different row, multiple rows): count=0, advance col_idx, go to SCAN.
  - REPORT: lasts exactly one cycle.
    - valid=1 for this cycle; scan_data <= 1 << (row_idx*3+col_idx) on entry.
    - Then go to RELEASE with count=0.
  - RELEASE: col_idx held. On each tick:
    - rs==4'b1111: count+1. When count reaches DEBOUNCE, advance col_idx, go to SCAN.
    - Any row low: count=0.
    - No further valid until the key is released: no auto-repeat.
- valid is never high on two consecutive cycles. Consecutive valid pulses are at least 2*DEBOUNCE*SCAN_DIV cycles apart.
- scan_data holds its value between pulses and changes only together with valid. It is always zero or one-hot.
- Latency: the first qualifying tick is counted as 1. valid rises in the cycle after the DEBOUNCE-th qualifying tick. Row-to-sample delay is 2 cycles (synchronizer).
- Simultaneous keys:
  - Two keys in the same column (multiple rows low) are ignored.
  - A second key in another column is invisible while the first is held, because the column is frozen.
- Glitch shorter than one tick: ignored unless it lands on a tick edge; then debounce rejects it.
- Reset asserted mid-operation (including during REPORT) returns everything to reset values immediately; no valid is emitted.

Decomposition:
- Shared package:
  - Key code constants KEY_1..KEY_9, KEY_STAR, KEY_0, KEY_HASH (12-bit one-hot).
  - NUM_ROWS=4, NUM_COLS=3.
  - State encoding constants.
  - The display block uses the same key constants.
- One natural sub-module, kp_sync2: a 4-bit two-flop synchronizer with async active-low reset to all-ones.

Test Plan (bench overrides SCAN_DIV=4, DEBOUNCE=3):
- Idle, rows all high for 100 cycles -> col cycles 110,101,011 every 4 cycles; valid never asserts; scan_data stays 12'h000.
- Hold key 5 (row1 low only while col[1]=0) until release -> exactly one valid pulse with scan_data=12'h010, 3 ticks after first detection; col frozen at 101 until 3 clean release ticks.
- Press # (row3, col2), release, then press * (row3, col0) -> pulses with 12'h800 then 12'h200; scan_data holds 12'h800 between them.
- Key 8 bounces (row2 toggles low/high on alternate ticks for 4 ticks) then holds steady -> no valid during bounce; one pulse 12'h080 after 3 steady ticks.
- Rows 0 and 2 both low in column 0 (keys 1 and 7) -> no valid; scanning continues to advance.
- Assert rst in the REPORT cycle while key 0 is accepted -> valid=0, scan_data=12'h000, col=110 immediately; after rst release with the key still held -> a fresh single 12'h400 pulse.

Source files
------------

// File: rtl/keypad_scanner_pkg.sv
// Shared definitions for the 4x3 keypad scanner and its consumers.
// Key codes are one-hot with bit index row*3 + col.
package keypad_scanner_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 3;
  localparam int NUM_KEYS = NUM_ROWS * NUM_COLS;

  localparam logic [NUM_KEYS-1:0] KEY_1    = 12'h001;
  localparam logic [NUM_KEYS-1:0] KEY_2    = 12'h002;
  localparam logic [NUM_KEYS-1:0] KEY_3    = 12'h004;
  localparam logic [NUM_KEYS-1:0] KEY_4    = 12'h008;
  localparam logic [NUM_KEYS-1:0] KEY_5    = 12'h010;
  localparam logic [NUM_KEYS-1:0] KEY_6    = 12'h020;
  localparam logic [NUM_KEYS-1:0] KEY_7    = 12'h040;
  localparam logic [NUM_KEYS-1:0] KEY_8    = 12'h080;
  localparam logic [NUM_KEYS-1:0] KEY_9    = 12'h100;
  localparam logic [NUM_KEYS-1:0] KEY_STAR = 12'h200;
  localparam logic [NUM_KEYS-1:0] KEY_0    = 12'h400;
  localparam logic [NUM_KEYS-1:0] KEY_HASH = 12'h800;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_REPORT   = 2'd2,
    ST_RELEASE  = 2'd3
  } kp_state_e;

  function automatic logic [NUM_KEYS-1:0] key_code(input logic [1:0] row_idx,
                                                   input logic [1:0] col_idx);
    logic [3:0] bit_idx;
    bit_idx = 4'(row_idx) * 4'd3 + 4'(col_idx);
    return {{(NUM_KEYS-1){1'b0}}, 1'b1} << bit_idx;
  endfunction

endpackage

// File: rtl/kp_sync2.sv
// Two-flop synchronizer for the keypad row lines; idles at all-ones
// (no key pressed) out of reset.
module kp_sync2 #(
  parameter int W = 4
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_s1, r_s2;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1 <= '1;
      r_s2 <= '1;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
    end
  end

  assign o_q = r_s2;

endmodule

// File: rtl/keypad_scanner.sv
// 4x3 matrix keypad scanner: walks the columns, debounces press and release,
// and emits one one-hot code with a single-cycle valid per accepted press.
module keypad_scanner
  import keypad_scanner_pkg::*;
#(
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_ROWS-1:0] row,
  output logic [NUM_COLS-1:0] col,
  output logic [NUM_KEYS-1:0] scan_data,
  output logic                valid
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE);

  kp_state_e           r_state, w_state_nxt;
  logic [DW-1:0]       r_div;
  logic [1:0]          r_col_idx, w_col_nxt, w_col_adv;
  logic [1:0]          r_row_idx, w_row_nxt, w_hit_row;
  logic [CW-1:0]       r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [NUM_KEYS-1:0] r_scan_data;
  logic [NUM_ROWS-1:0] w_rs, w_low;
  logic                w_tick, w_single, w_load;

  kp_sync2 #(.W(NUM_ROWS)) u_sync (
    .i_clk  (clk),
    .i_rst_n(rst),
    .i_d    (row),
    .o_q    (w_rs)
  );

  assign w_tick    = (r_div == DIV_LAST);
  assign w_low     = ~w_rs;
  // Exactly one row pulled low: nonzero and a power of two.
  assign w_single  = (w_low != '0) && ((w_low & (w_low - NUM_ROWS'(1))) == '0);
  assign w_cnt_inc = r_cnt + CW'(1);
  assign w_col_adv = (r_col_idx == 2'd2) ? 2'd0 : r_col_idx + 2'd1;

  always_comb begin
    w_hit_row = 2'd0;
    for (int i = 0; i < NUM_ROWS; i++)
      if (w_low[i]) w_hit_row = 2'(i);
  end

  assign col       = ~(NUM_COLS'(1) << r_col_idx);
  assign valid     = (r_state == ST_REPORT);
  assign scan_data = r_scan_data;

  always_comb begin
    w_state_nxt = r_state;
    w_col_nxt   = r_col_idx;
    w_row_nxt   = r_row_idx;
    w_cnt_nxt   = r_cnt;
    w_load      = 1'b0;
    case (r_state)
      ST_SCAN: if (w_tick) begin
        if (w_single) begin
          w_row_nxt = w_hit_row;
          w_cnt_nxt = CW'(1);
          if (DEBOUNCE == 1) begin
            w_state_nxt = ST_REPORT;
            w_load      = 1'b1;
          end else begin
            w_state_nxt = ST_DEBOUNCE;
          end
        end else begin
          w_col_nxt = w_col_adv;
        end
      end
      ST_DEBOUNCE: if (w_tick) begin
        if (w_single && (w_hit_row == r_row_idx)) begin
          w_cnt_nxt = w_cnt_inc;
          if (w_cnt_inc == DB_LAST) begin
            w_state_nxt = ST_REPORT;
            w_load      = 1'b1;
          end
        end else begin
          w_cnt_nxt   = '0;
          w_col_nxt   = w_col_adv;
          w_state_nxt = ST_SCAN;
        end
      end
      ST_REPORT: begin
        w_state_nxt = ST_RELEASE;
        w_cnt_nxt   = '0;
      end
      ST_RELEASE: if (w_tick) begin
        // Column stays frozen until the key has been seen released cleanly.
        if (w_rs == '1) begin
          w_cnt_nxt = w_cnt_inc;
          if (w_cnt_inc == DB_LAST) begin
            w_cnt_nxt   = '0;
            w_col_nxt   = w_col_adv;
            w_state_nxt = ST_SCAN;
          end
        end else begin
          w_cnt_nxt = '0;
        end
      end
      default: w_state_nxt = ST_SCAN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_SCAN;
      r_div       <= '0;
      r_col_idx   <= '0;
      r_row_idx   <= '0;
      r_cnt       <= '0;
      r_scan_data <= '0;
    end else begin
      r_div     <= w_tick ? '0 : r_div + DW'(1);
      r_state   <= w_state_nxt;
      r_col_idx <= w_col_nxt;
      r_row_idx <= w_row_nxt;
      r_cnt     <= w_cnt_nxt;
      if (w_load) r_scan_data <= key_code(w_row_nxt, r_col_idx);
    end
  end

endmodule
